cache_port_arbiter: RTL and testbench

CACHE_PORT_ARBITER -- requirements
Module: cache_port_arbiter

---
 rtl/cache_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_cache_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-command cache controller.
// Define ARB_STATS_EN to add saturating per-port grant counters (grant_cnt0/1).
module cache_port_arbiter #(
    parameter int ADDRESS_WORD_SIZE = 32,
    parameter int STAT_WIDTH        = 16
) (
    input  logic                         clk,
    input  logic                         rst_b,
    input  logic                         req0,
    input  logic                         req1,
    input  logic                         op0,
    input  logic                         op1,
    input  logic [ADDRESS_WORD_SIZE-1:0] addr0,
    input  logic [ADDRESS_WORD_SIZE-1:0] addr1,
    input  logic [7:0]                   wdata0,
    input  logic [7:0]                   wdata1,
    output logic                         done0,
    output logic                         done1,
    output logic [7:0]                   rdata0,
    output logic [7:0]                   rdata1,
    output logic                         hit0,
    output logic                         hit1,
    output logic                         c_req,
    output logic                         c_opcode,
    output logic [ADDRESS_WORD_SIZE-1:0] c_address,
    output logic [7:0]                   c_data_in,
    input  logic                         c_ready,
    input  logic [7:0]                   c_data_out,
    input  logic                         c_hit
`ifdef ARB_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]        grant_cnt0,
    output logic [STAT_WIDTH-1:0]        grant_cnt1
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                         state_q, state_d;
    logic                           rr_q, rr_d;
    logic                           win_q, win_d;
    logic                           win_sel;
    logic                           grant;
    logic                           c_req_q, c_req_d;
    logic                           c_opcode_q, c_opcode_d;
    logic [ADDRESS_WORD_SIZE-1:0]   c_address_q, c_address_d;
    logic [7:0]                     c_data_in_q, c_data_in_d;
    logic                           done0_q, done0_d, done1_q, done1_d;
    logic [7:0]                     rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                           hit0_q, hit0_d, hit1_q, hit1_d;

    // Single requester wins outright; rr only breaks ties.
    assign win_sel = (req0 && req1) ? rr_q : req1;
    assign grant   = (state_q == IDLE) && (req0 || req1);

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        win_d       = win_q;
        c_req_d     = 1'b0;
        c_opcode_d  = c_opcode_q;
        c_address_d = c_address_q;
        c_data_in_d = c_data_in_q;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        hit0_d      = hit0_q;
        hit1_d      = hit1_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    win_d       = win_sel;
                    c_opcode_d  = win_sel ? op1    : op0;
                    c_address_d = win_sel ? addr1  : addr0;
                    c_data_in_d = win_sel ? wdata1 : wdata0;
                    c_req_d     = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                // Response is presented straight from the capture flops during DONE.
                if (c_ready) begin
                    state_d = DONE;
                    if (win_q) begin
                        done1_d  = 1'b1;
                        rdata1_d = c_data_out;
                        hit1_d   = c_hit;
                    end else begin
                        done0_d  = 1'b1;
                        rdata0_d = c_data_out;
                        hit0_d   = c_hit;
                    end
                end
            end
            DONE: begin
                rr_d    = ~win_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            win_q       <= 1'b0;
            c_req_q     <= 1'b0;
            c_opcode_q  <= 1'b0;
            c_address_q <= '0;
            c_data_in_q <= '0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            hit0_q      <= 1'b0;
            hit1_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            win_q       <= win_d;
            c_req_q     <= c_req_d;
            c_opcode_q  <= c_opcode_d;
            c_address_q <= c_address_d;
            c_data_in_q <= c_data_in_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            hit0_q      <= hit0_d;
            hit1_q      <= hit1_d;
        end
    end

    assign c_req     = c_req_q;
    assign c_opcode  = c_opcode_q;
    assign c_address = c_address_q;
    assign c_data_in = c_data_in_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign hit0      = hit0_q;
    assign hit1      = hit1_q;

`ifdef ARB_STATS_EN
    logic [STAT_WIDTH-1:0] gcnt0_q, gcnt0_d, gcnt1_q, gcnt1_d;

    // Counts entries into ISSUE; sticks at all-ones.
    always_comb begin
        gcnt0_d = gcnt0_q;
        gcnt1_d = gcnt1_q;
        if (grant && !win_sel && (gcnt0_q != '1)) gcnt0_d = gcnt0_q + STAT_WIDTH'(1);
        if (grant &&  win_sel && (gcnt1_q != '1)) gcnt1_d = gcnt1_q + STAT_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            gcnt0_q <= '0;
            gcnt1_q <= '0;
        end else begin
            gcnt0_q <= gcnt0_d;
            gcnt1_q <= gcnt1_d;
        end
    end

    assign grant_cnt0 = gcnt0_q;
    assign grant_cnt1 = gcnt1_q;
`else
    // Statistics build option off: no grant counters.
`endif

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter: expected transactions are queued when
// requests are driven and retired by a monitor on each done pulse.
module tb_cache_port_arbiter;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_b;
    logic          req0, req1, op0, op1;
    logic [AW-1:0] addr0, addr1;
    logic [7:0]    wdata0, wdata1;
    logic          done0, done1, hit0, hit1;
    logic [7:0]    rdata0, rdata1;
    logic          c_req, c_opcode;
    logic [AW-1:0] c_address;
    logic [7:0]    c_data_in;
    logic          c_ready, c_hit;
    logic [7:0]    c_data_out;
`ifdef ARB_STATS_EN
    logic [1:0]    grant_cnt0, grant_cnt1;
`endif

    cache_port_arbiter #(.ADDRESS_WORD_SIZE(AW), .STAT_WIDTH(2)) dut (
        .clk(clk), .rst_b(rst_b),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
        .hit0(hit0), .hit1(hit1),
        .c_req(c_req), .c_opcode(c_opcode), .c_address(c_address), .c_data_in(c_data_in),
        .c_ready(c_ready), .c_data_out(c_data_out), .c_hit(c_hit)
`ifdef ARB_STATS_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          port;
        bit          op;
        logic [31:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        bit          hit;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   creq_cyc = 0;
    int   done_cyc = 0;
    int   lat   = 0;
    bit   stray = 1'b0;
    bit   pending = 1'b0;
    int   cnt   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Cache controller model: answers lat WAIT cycles after seeing c_req.
    // Read data is a fixed function of the address so the bench can predict it.
    initial begin
        c_ready = 1'b0; c_data_out = '0; c_hit = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_b) begin
                pending = 1'b0;
                c_ready = 1'b0;
            end else if (pending) begin
                if (cnt == 0) begin
                    c_ready    = 1'b1;
                    c_data_out = c_address[7:0] ^ 8'hA5;
                    c_hit      = ~c_address[0];
                    pending    = 1'b0;
                end else begin
                    cnt--;
                    c_ready = stray;
                end
            end else begin
                c_ready = stray;
                if (c_req) begin
                    pending = 1'b1;
                    cnt     = lat;
                end
            end
        end
    end

    // Monitor: command check on c_req, scoreboard retire on done.
    always @(negedge clk) begin
        if (!rst_b) begin
            if (c_req) begin
                creq_cyc = cyc;
                chk("creq_expected", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    chk("c_opcode", c_opcode, exp_q[0].op);
                    chk("c_address", c_address, exp_q[0].addr);
                    if (exp_q[0].op) chk("c_data_in", c_data_in, exp_q[0].wdata);
                end
            end
            if (done0 || done1) begin
                done_cyc = cyc;
                chk("done_exclusive", done0 & done1, 0);
                chk("done_expected", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("done_port", done1, mon_e.port);
                    chk("rdata", done1 ? rdata1 : rdata0, mon_e.rdata);
                    chk("hit", done1 ? hit1 : hit0, mon_e.hit);
                end
            end
        end
    end

    task automatic wait_done(input bit port, input int maxc);
        int n;
        n = 0;
        @(negedge clk);
        while (!(port ? done1 : done0) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk(port ? "done1_seen" : "done0_seen", port ? done1 : done0, 1);
        #1;
    endtask

    task automatic wait_creq(input int maxc);
        int n;
        n = 0;
        @(negedge clk);
        while (!c_req && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("creq_seen", c_req, 1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_outs1"}, {done0, done1, hit0, hit1, c_req, c_opcode}, 0);
        chk({tag, "_rdata"}, {rdata0, rdata1}, 0);
        chk({tag, "_caddr"}, c_address, 0);
        chk({tag, "_cdata"}, c_data_in, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        rst_b = 1'b1;
        req0 = 0; req1 = 0; op0 = 0; op1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_b = 1'b0;
        @(negedge clk);

        // Single read at minimum latency
        lat = 0;
        exp_q.push_back('{1'b0, 1'b0, 32'h100, 8'h00, 8'hA5, 1'b1});
        op0 = 0; addr0 = 32'h100; req0 = 1; t0 = cyc;
        wait_done(0, 10);
        req0 = 0;
        chk("lat_creq", creq_cyc - t0, 1);
        chk("lat_done", done_cyc - t0, 3);

        // Write from port 1 at all-ones address, command held through WAIT
        lat = 3;
        exp_q.push_back('{1'b1, 1'b1, 32'hFFFF_FFFF, 8'h3C, 8'h5A, 1'b0});
        op1 = 1; wdata1 = 8'h3C; addr1 = 32'hFFFF_FFFF; req1 = 1;
        wait_creq(10);
        repeat (4) begin
            @(negedge clk);
            chk("hold_addr", c_address, 32'hFFFF_FFFF);
            chk("hold_op", c_opcode, 1);
            chk("hold_wdata", c_data_in, 8'h3C);
            chk("hold_creq_low", c_req, 0);
        end
        wait_done(1, 5);
        req1 = 0;
        chk("rdata0_hold", rdata0, 8'hA5);
        chk("hit0_hold", hit0, 1);

        // Long stall in WAIT
        lat = 20;
        exp_q.push_back('{1'b0, 1'b0, 32'h22, 8'h00, 8'h87, 1'b1});
        op0 = 0; addr0 = 32'h22; req0 = 1;
        wait_creq(10);
        repeat (20) begin
            @(negedge clk);
            chk("stall_quiet", {c_req, done0, done1}, 0);
        end
        wait_done(0, 3);
        req0 = 0;

        // Spurious c_ready while idle must not start or finish anything
        stray = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("stray_quiet", {c_req, done0, done1}, 0);
        end
        stray = 1'b0;
        @(negedge clk);

        // Reset during WAIT, then contention from reset (rr must restart at 0)
        lat = 10;
        exp_q.push_back('{1'b0, 1'b0, 32'h10, 8'h00, 8'hB5, 1'b1});
        op0 = 0; addr0 = 32'h10; req0 = 1;
        wait_creq(10);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        #1;
        check_zero("midreset");
        exp_q.delete();
        lat = 1;
        addr0 = 32'h40; addr1 = 32'h81; op0 = 0; op1 = 0; req1 = 1;
        for (int k = 0; k < 4; k++)
            exp_q.push_back(k[0] ? '{1'b1, 1'b0, 32'h81, 8'h00, 8'h24, 1'b0}
                                 : '{1'b0, 1'b0, 32'h40, 8'h00, 8'hE5, 1'b1});
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        for (int k = 0; k < 4; k++) wait_done(k[0], 12);
        req0 = 0; req1 = 0;
        chk("contention_drained", exp_q.size(), 0);

        // Reset during WAIT, then lone port-1 request
        lat = 10;
        exp_q.push_back('{1'b0, 1'b0, 32'h10, 8'h00, 8'hB5, 1'b1});
        addr0 = 32'h10; req0 = 1;
        wait_creq(10);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        req0 = 0;
        #1;
        chk("reset_done_low", {done0, done1, c_req}, 0);
        exp_q.delete();
        exp_q.push_back('{1'b1, 1'b0, 32'h7E, 8'h00, 8'hDB, 1'b1});
        addr1 = 32'h7E; op1 = 0; req1 = 1;
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        wait_done(1, 12);
        req1 = 0;

`ifdef ARB_STATS_EN
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        chk("gcnt_reset", {grant_cnt0, grant_cnt1}, 0);
        lat = 0;
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back('{1'b0, 1'b0, 32'h100, 8'h00, 8'hA5, 1'b1});
            addr0 = 32'h100; op0 = 0; req0 = 1;
            wait_done(0, 10);
            req0 = 0;
            @(negedge clk);
        end
        chk("gcnt0_sat", grant_cnt0, 2'd3);
        chk("gcnt1_zero", grant_cnt1, 2'd0);
`endif

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
